// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter
// Purpose  : Round-robin sharing of one waitrequest/readdatavalid memory port
//            between instruction fetch (I) and load/store (D) requesters.
// Options  : define MEM_TIMEOUT_EN to bound WAIT_VALID and add the m_err port.
// Revision : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_gnt,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_rvalid,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_rvalid,
  output logic [ADDR_W-1:0] m_addr,
  output logic              m_read,
  output logic              m_write,
  output logic [DATA_W-1:0] m_wdata,
  input  logic              m_waitrequest,
  input  logic [DATA_W-1:0] m_rdata,
  input  logic              m_rdatavalid,
`ifdef MEM_TIMEOUT_EN
  output logic              busy,
  output logic              m_err
`else
  output logic              busy
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_ISSUE      = 2'd1,
    ST_WAIT_VALID = 2'd2
  } state_t;

  state_t r_state;
  logic   r_owner_d;
  logic   r_last_d;
  logic   w_pick_d;
  logic   w_we;

  // D wins only when I is absent or I owned the previous transaction.
  assign w_pick_d = d_req & (~i_req | ~r_last_d);
  assign w_we     = w_pick_d & d_we;

  // The wait counter is 8 bits wide; out-of-range values are not meaningful.
  if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_timeout_out_of_range
  end

`ifdef MEM_TIMEOUT_EN
  localparam logic [7:0] c_timeout_last = 8'(TIMEOUT - 1);
  logic [7:0] r_wait_cnt;
  logic       w_timeout;
  assign w_timeout = (r_wait_cnt == c_timeout_last);
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= ST_IDLE;
      r_owner_d <= 1'b0;
      r_last_d  <= 1'b1;
      i_gnt     <= 1'b0;
      d_gnt     <= 1'b0;
      i_rvalid  <= 1'b0;
      d_rvalid  <= 1'b0;
      i_rdata   <= '0;
      d_rdata   <= '0;
      m_addr    <= '0;
      m_wdata   <= '0;
      m_read    <= 1'b0;
      m_write   <= 1'b0;
      busy      <= 1'b0;
`ifdef MEM_TIMEOUT_EN
      m_err      <= 1'b0;
      r_wait_cnt <= 8'd0;
`endif
    end else begin
      i_gnt    <= 1'b0;
      d_gnt    <= 1'b0;
      i_rvalid <= 1'b0;
      d_rvalid <= 1'b0;
`ifdef MEM_TIMEOUT_EN
      m_err    <= 1'b0;
`endif
      case (r_state)
        ST_IDLE: begin
          if (i_req || d_req) begin
            r_owner_d <= w_pick_d;
            r_last_d  <= w_pick_d;
            i_gnt     <= ~w_pick_d;
            d_gnt     <= w_pick_d;
            m_addr    <= w_pick_d ? d_addr : i_addr;
            m_wdata   <= w_pick_d ? d_wdata : '0;
            m_read    <= ~w_we;
            m_write   <= w_we;
            busy      <= 1'b1;
            r_state   <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (!m_waitrequest) begin
            m_read  <= 1'b0;
            m_write <= 1'b0;
            if (m_write) begin
              busy    <= 1'b0;
              r_state <= ST_IDLE;
            end else begin
              r_state <= ST_WAIT_VALID;
`ifdef MEM_TIMEOUT_EN
              r_wait_cnt <= 8'd0;
`endif
            end
          end
        end
        ST_WAIT_VALID: begin
          if (m_rdatavalid) begin
            if (r_owner_d) begin
              d_rdata  <= m_rdata;
              d_rvalid <= 1'b1;
            end else begin
              i_rdata  <= m_rdata;
              i_rvalid <= 1'b1;
            end
            busy    <= 1'b0;
            r_state <= ST_IDLE;
          end
`ifdef MEM_TIMEOUT_EN
          else if (w_timeout) begin
            if (r_owner_d) begin
              d_rdata  <= '1;
              d_rvalid <= 1'b1;
            end else begin
              i_rdata  <= '1;
              i_rvalid <= 1'b1;
            end
            m_err   <= 1'b1;
            busy    <= 1'b0;
            r_state <= ST_IDLE;
          end else begin
            r_wait_cnt <= r_wait_cnt + 8'd1;
          end
`endif
        end
        default: begin
          busy    <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_port_arbiter
// Purpose  : Directed vector table plus reset/timeout sequences for
//            mem_port_arbiter (timeout part active with MEM_TIMEOUT_EN).
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        i_req = 1'b0;
  logic [15:0] i_addr = '0;
  logic        i_gnt;
  logic [15:0] i_rdata;
  logic        i_rvalid;
  logic        d_req = 1'b0;
  logic        d_we = 1'b0;
  logic [15:0] d_addr = '0;
  logic [15:0] d_wdata = '0;
  logic        d_gnt;
  logic [15:0] d_rdata;
  logic        d_rvalid;
  logic [15:0] m_addr;
  logic        m_read;
  logic        m_write;
  logic [15:0] m_wdata;
  logic        m_waitrequest = 1'b0;
  logic [15:0] m_rdata = '0;
  logic        m_rdatavalid = 1'b0;
  logic        busy;
`ifdef MEM_TIMEOUT_EN
  logic        m_err;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  mem_port_arbiter #(.ADDR_W(16), .DATA_W(16), .TIMEOUT(4)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rdata(i_rdata), .i_rvalid(i_rvalid),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rdata(d_rdata), .d_rvalid(d_rvalid),
    .m_addr(m_addr), .m_read(m_read), .m_write(m_write), .m_wdata(m_wdata),
    .m_waitrequest(m_waitrequest), .m_rdata(m_rdata), .m_rdatavalid(m_rdatavalid),
`ifdef MEM_TIMEOUT_EN
    .busy(busy), .m_err(m_err)
`else
    .busy(busy)
`endif
  );

  always #5 clk = ~clk;

  // ef bit order: {i_gnt, d_gnt, i_rvalid, d_rvalid, m_read, m_write, busy}
  typedef struct {
    logic        ireq;
    logic [15:0] iaddr;
    logic        dreq;
    logic        dwe;
    logic [15:0] daddr;
    logic [15:0] dwdata;
    logic        wr;
    logic        rdv;
    logic [15:0] rdata;
    logic [6:0]  ef;
    logic [15:0] ea;
    logic [15:0] ew;
    logic [15:0] eir;
    logic [15:0] edr;
  } vec_t;

  vec_t tv[$];

  function automatic vec_t mk(
      input logic ireq, input logic [15:0] iaddr, input logic dreq, input logic dwe,
      input logic [15:0] daddr, input logic [15:0] dwdata, input logic wr, input logic rdv,
      input logic [15:0] rdata, input logic [6:0] ef, input logic [15:0] ea,
      input logic [15:0] ew, input logic [15:0] eir, input logic [15:0] edr);
    vec_t v;
    v.ireq = ireq; v.iaddr = iaddr; v.dreq = dreq; v.dwe = dwe;
    v.daddr = daddr; v.dwdata = dwdata; v.wr = wr; v.rdv = rdv; v.rdata = rdata;
    v.ef = ef; v.ea = ea; v.ew = ew; v.eir = eir; v.edr = edr;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [6:0] flags();
    return {i_gnt, d_gnt, i_rvalid, d_rvalid, m_read, m_write, busy};
  endfunction

  initial begin
    // Fetch read, zero wait
    tv.push_back(mk(1,16'h0010,0,0,16'h0000,16'h0000,0,0,16'h0000,7'b1000101,16'h0010,16'h0000,16'h0000,16'h0000));
    tv.push_back(mk(0,16'h0010,0,0,16'h0000,16'h0000,0,0,16'h0000,7'b0000001,16'h0000,16'h0000,16'h0000,16'h0000));
    tv.push_back(mk(0,16'h0000,0,0,16'h0000,16'h0000,0,1,16'h1234,7'b0010000,16'h0000,16'h0000,16'h1234,16'h0000));
    tv.push_back(mk(0,16'h0000,0,0,16'h0000,16'h0000,0,0,16'h0000,7'b0000000,16'h0000,16'h0000,16'h1234,16'h0000));
    // Store with 3 stall cycles; address changes after gnt, stray rdatavalid in ISSUE
    tv.push_back(mk(0,16'h0000,1,1,16'h0200,16'hBEEF,1,0,16'h0000,7'b0100011,16'h0200,16'hBEEF,16'h1234,16'h0000));
    tv.push_back(mk(0,16'h0000,0,1,16'hFFFF,16'h0000,1,0,16'h0000,7'b0000011,16'h0200,16'hBEEF,16'h1234,16'h0000));
    tv.push_back(mk(0,16'h0000,0,0,16'hFFFF,16'h0000,1,1,16'h5555,7'b0000011,16'h0200,16'hBEEF,16'h1234,16'h0000));
    tv.push_back(mk(0,16'h0000,0,0,16'h0000,16'h0000,1,0,16'h0000,7'b0000011,16'h0200,16'hBEEF,16'h1234,16'h0000));
    tv.push_back(mk(0,16'h0000,0,0,16'h0000,16'h0000,0,0,16'h0000,7'b0000000,16'h0000,16'h0000,16'h1234,16'h0000));
    // Collision fairness: I, D, I, D
    tv.push_back(mk(1,16'h00A0,1,0,16'h00B0,16'h0000,0,0,16'h0000,7'b1000101,16'h00A0,16'h0000,16'h1234,16'h0000));
    tv.push_back(mk(0,16'h00A0,1,0,16'h00B0,16'h0000,0,0,16'h0000,7'b0000001,16'h0000,16'h0000,16'h1234,16'h0000));
    tv.push_back(mk(1,16'h00A0,1,0,16'h00B0,16'h0000,0,1,16'h1111,7'b0010000,16'h0000,16'h0000,16'h1111,16'h0000));
    tv.push_back(mk(1,16'h00A2,1,0,16'h00B0,16'h0000,0,0,16'h0000,7'b0100101,16'h00B0,16'h0000,16'h1111,16'h0000));
    tv.push_back(mk(1,16'h00A2,0,0,16'h00B0,16'h0000,0,0,16'h0000,7'b0000001,16'h0000,16'h0000,16'h1111,16'h0000));
    tv.push_back(mk(1,16'h00A2,1,0,16'h00B2,16'h0000,0,1,16'h2222,7'b0001000,16'h0000,16'h0000,16'h1111,16'h2222));
    tv.push_back(mk(1,16'h00A2,1,0,16'h00B2,16'h0000,0,0,16'h0000,7'b1000101,16'h00A2,16'h0000,16'h1111,16'h2222));
    tv.push_back(mk(0,16'h00A2,1,0,16'h00B2,16'h0000,0,0,16'h0000,7'b0000001,16'h0000,16'h0000,16'h1111,16'h2222));
    tv.push_back(mk(1,16'h00A4,1,0,16'h00B2,16'h0000,0,1,16'h3333,7'b0010000,16'h0000,16'h0000,16'h3333,16'h2222));
    tv.push_back(mk(1,16'h00A4,1,0,16'h00B2,16'h0000,0,0,16'h0000,7'b0100101,16'h00B2,16'h0000,16'h3333,16'h2222));
    tv.push_back(mk(1,16'h00A4,0,0,16'h00B2,16'h0000,0,0,16'h0000,7'b0000001,16'h0000,16'h0000,16'h3333,16'h2222));
    tv.push_back(mk(0,16'h0000,0,0,16'h0000,16'h0000,0,1,16'h4444,7'b0001000,16'h0000,16'h0000,16'h3333,16'h4444));
    // Load routing with i_req pending
    tv.push_back(mk(0,16'h0000,1,0,16'h0300,16'h0000,0,0,16'h0000,7'b0100101,16'h0300,16'h0000,16'h3333,16'h4444));
    tv.push_back(mk(1,16'h0400,0,0,16'h0000,16'h0000,0,0,16'h0000,7'b0000001,16'h0000,16'h0000,16'h3333,16'h4444));
    tv.push_back(mk(1,16'h0400,0,0,16'h0000,16'h0000,0,1,16'h00AA,7'b0001000,16'h0000,16'h0000,16'h3333,16'h00AA));
    tv.push_back(mk(1,16'h0400,0,0,16'h0000,16'h0000,0,0,16'h0000,7'b1000101,16'h0400,16'h0000,16'h3333,16'h00AA));
    tv.push_back(mk(0,16'h0000,0,0,16'h0000,16'h0000,0,0,16'h0000,7'b0000001,16'h0000,16'h0000,16'h3333,16'h00AA));
    tv.push_back(mk(0,16'h0000,0,0,16'h0000,16'h0000,0,1,16'h0F0F,7'b0010000,16'h0000,16'h0000,16'h0F0F,16'h00AA));
    tv.push_back(mk(0,16'h0000,0,0,16'h0000,16'h0000,0,1,16'hDEAD,7'b0000000,16'h0000,16'h0000,16'h0F0F,16'h00AA));
    // Zero-wait write followed back-to-back by a fetch
    tv.push_back(mk(0,16'h0000,1,1,16'h0010,16'h1357,0,0,16'h0000,7'b0100011,16'h0010,16'h1357,16'h0F0F,16'h00AA));
    tv.push_back(mk(1,16'h0500,0,0,16'h0000,16'h0000,0,0,16'h0000,7'b0000000,16'h0000,16'h0000,16'h0F0F,16'h00AA));
    tv.push_back(mk(1,16'h0500,0,0,16'h0000,16'h0000,0,0,16'h0000,7'b1000101,16'h0500,16'h0000,16'h0F0F,16'h00AA));
    tv.push_back(mk(0,16'h0000,0,0,16'h0000,16'h0000,0,0,16'h0000,7'b0000001,16'h0000,16'h0000,16'h0F0F,16'h00AA));
    tv.push_back(mk(0,16'h0000,0,0,16'h0000,16'h0000,0,1,16'h2468,7'b0010000,16'h0000,16'h0000,16'h2468,16'h00AA));

    // Reset state
    step();
    step();
    check("reset flags", 32'(flags()), 32'h0);
    check("reset rdata", {i_rdata, d_rdata}, 32'h0);
    check("reset maddr/wdata", {m_addr, m_wdata}, 32'h0);
    reset = 1'b1;

    for (int k = 0; k < tv.size(); k++) begin
      i_req = tv[k].ireq; i_addr = tv[k].iaddr;
      d_req = tv[k].dreq; d_we = tv[k].dwe; d_addr = tv[k].daddr; d_wdata = tv[k].dwdata;
      m_waitrequest = tv[k].wr; m_rdatavalid = tv[k].rdv; m_rdata = tv[k].rdata;
      step();
      check($sformatf("v%0d flags", k), 32'(flags()), 32'(tv[k].ef));
      if (tv[k].ef[2] || tv[k].ef[1]) check($sformatf("v%0d m_addr", k), 32'(m_addr), 32'(tv[k].ea));
      if (tv[k].ef[1]) check($sformatf("v%0d m_wdata", k), 32'(m_wdata), 32'(tv[k].ew));
      check($sformatf("v%0d i_rdata", k), 32'(i_rdata), 32'(tv[k].eir));
      check($sformatf("v%0d d_rdata", k), 32'(d_rdata), 32'(tv[k].edr));
    end
    i_req = 0; d_req = 0; d_we = 0; m_waitrequest = 0; m_rdatavalid = 0;

    // Async reset during WAIT_VALID; last owner was I before reset
    i_req = 1; i_addr = 16'h0700;
    step();
    check("rst-seq gnt", 32'(flags()), 32'(7'b1000101));
    i_req = 0;
    step();
    check("rst-seq wait", 32'(flags()), 32'(7'b0000001));
    #1 reset = 1'b0;
    #1;
    check("rst-async flags", 32'(flags()), 32'h0);
    check("rst-async rdata", {i_rdata, d_rdata}, 32'h0);
    check("rst-async maddr", 32'(m_addr), 32'h0);
    @(posedge clk);
    #1 reset = 1'b1;
    m_rdatavalid = 1; m_rdata = 16'h9999;
    step();
    check("rst-late rdv flags", 32'(flags()), 32'h0);
    check("rst-late rdv rdata", {i_rdata, d_rdata}, 32'h0);
    m_rdatavalid = 0;
    i_req = 1; i_addr = 16'h0800; d_req = 1; d_we = 0; d_addr = 16'h0900;
    step();
    check("rst-collision I wins", 32'(flags()), 32'(7'b1000101));
    check("rst-collision addr", 32'(m_addr), 32'h0800);
    i_req = 0; d_req = 0;
    step();
    m_rdatavalid = 1; m_rdata = 16'h7777;
    step();
    check("rst-read rvalid", 32'(flags()), 32'(7'b0010000));
    check("rst-read rdata", 32'(i_rdata), 32'h7777);
    m_rdatavalid = 0;
    step();

`ifdef MEM_TIMEOUT_EN
    i_req = 1; i_addr = 16'h0055;
    step();
    i_req = 0;
    step();
    for (int k = 0; k < 4; k++) begin
      step();
      check($sformatf("to cyc%0d rvalid/err", k), {i_rvalid, m_err}, (k == 3) ? 32'h3 : 32'h0);
    end
    check("to rdata ones", 32'(i_rdata), 32'hFFFF);
    check("to busy", 32'(busy), 32'h0);
    m_rdatavalid = 1; m_rdata = 16'h1212;
    step();
    check("to late rdv", {i_rvalid, d_rvalid, m_err}, 32'h0);
    check("to late rdata", 32'(i_rdata), 32'hFFFF);
    m_rdatavalid = 0;
    i_req = 1; i_addr = 16'h0066;
    step();
    check("to next gnt", 32'(flags()), 32'(7'b1000101));
    i_req = 0;
    step();
    m_rdatavalid = 1; m_rdata = 16'h3434;
    step();
    check("to next rvalid/err", {i_rvalid, m_err}, 32'h2);
    check("to next rdata", 32'(i_rdata), 32'h3434);
    m_rdatavalid = 0;
    step();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
